// File: rtl/dm_responder.sv
// Handshaked data-memory responder.
// Accepts one load/store at a time, performs it after a fixed wait-state latency,
// and holds the response until the initiator takes it.
module dm_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state;
  state_t state_next;

  logic [3:0]  count;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic [31:0] mem [DEPTH];

  logic                  accept;
  logic                  perform;
  logic                  release_rsp;
  logic                  addr_err;
  logic [DEPTH_LOG2-1:0] index;

  assign accept      = (state == S_IDLE) && req_valid;
  // The access happens on the edge that leaves WAIT.
  assign perform     = (state == S_WAIT) && (count == 4'd0);
  assign release_rsp = (state == S_RESP) && rsp_ready;
  assign index       = lat_addr[DEPTH_LOG2+1:2];
  // Misaligned, or any address bit above the array's byte range set.
  assign addr_err    = (lat_addr[1:0] != 2'b00) ||
                       ((lat_addr >> (DEPTH_LOG2 + 2)) != 32'd0);

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_RESP);

  // State register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: IDLE -> WAIT -> RESP -> IDLE, nothing else.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept)      state_next = S_WAIT;
      S_WAIT:  if (perform)     state_next = S_RESP;
      S_RESP:  if (release_rsp) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Request latch and wait-state counter; inputs are only sampled on accept.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count     <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
    end else if (accept) begin
      count     <= CNT_INIT;
      lat_we    <= req_we;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end else if ((state == S_WAIT) && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  // Response registers: loaded on RESP entry, cleared when the response is taken.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (perform) begin
      rsp_err   <= addr_err;
      rsp_rdata <= (addr_err || lat_we) ? 32'd0 : mem[index];
    end else if (release_rsp) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end
  end

  // Memory write port; the array has no reset so contents survive clr.
  always_ff @(posedge clk) begin
    if (perform && lat_we && !addr_err) begin
      mem[index] <= lat_wdata;
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: a cycle-level reference model driven by
// the same inputs, a per-cycle compare process, and directed transactions with
// hand-computed expectations.
module tb_dm_responder;

  localparam int LAT      = 2;
  localparam int DL2      = 8;
  localparam int MEM_TOP  = 4 * (1 << DL2);

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int checks = 0;
  int passes = 0;

  dm_responder #(.DEPTH_LOG2(DL2), .LATENCY(LAT)) dut (
    .clk       (clk),
    .clr       (clr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // A request taken at edge N answers at edge N+LAT and is held until rsp_ready.
  logic [31:0] mm [int];
  int          cyc = 0;
  int          m_due = 0;
  bit          m_pend = 0;
  bit          m_resp = 0;
  bit          m_we = 0;
  bit          m_err = 0;
  logic [31:0] m_addr = 0;
  logic [31:0] m_wdata = 0;
  logic [31:0] m_rdata = 0;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_pend  = 0;
      m_resp  = 0;
      m_rdata = 0;
      m_err   = 0;
    end else begin
      cyc++;
      if (m_resp) begin
        if (rsp_ready) begin
          m_resp  = 0;
          m_rdata = 0;
          m_err   = 0;
        end
      end else if (m_pend) begin
        if (cyc == m_due) begin
          m_pend = 0;
          m_resp = 1;
          m_err  = (m_addr % 4 != 0) || (m_addr >= 32'(MEM_TOP));
          if (m_err) m_rdata = 0;
          else if (m_we) begin
            mm[int'(m_addr / 4)] = m_wdata;
            m_rdata = 0;
          end else if (mm.exists(int'(m_addr / 4))) m_rdata = mm[int'(m_addr / 4)];
          else m_rdata = 'x;
        end
      end else if (req_valid) begin
        m_pend  = 1;
        m_due   = cyc + LAT;
        m_we    = req_we;
        m_addr  = req_addr;
        m_wdata = req_wdata;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit chk_en = 0;
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("cyc_rsp_valid", 32'(rsp_valid), 32'(m_resp));
      chk("cyc_busy",      32'(busy),      32'(m_pend || m_resp));
      chk("cyc_req_ready", 32'(req_ready), 32'(!(m_pend || m_resp)));
      chk("cyc_rsp_err",   32'(rsp_err),   32'(m_err));
      chk("cyc_rsp_rdata", rsp_rdata,      m_rdata);
    end
  end

  // ---------------- directed transactions ----------------
  task automatic transact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int stall, input bit hold_valid,
                          output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'd1);
    @(negedge clk);
    // Scramble the request bus: only the accept edge may matter.
    req_valid = hold_valid;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
    rd = rsp_rdata;
    er = rsp_err;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, rd);
      chk("hold_err",   32'(rsp_err), 32'(er));
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_valid", 32'(rsp_valid), 32'd0);
    chk("post_ready", 32'(req_ready), 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  // Stimulus sequence.
  initial begin
    #2 clr = 1'b0;
    chk_en = 1;
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    clr = 1'b1;
    @(negedge clk);
    chk("init_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("init_rsp_err",   32'(rsp_err),   32'd0);
    chk("init_rsp_rdata", rsp_rdata,      32'd0);
    chk("init_busy",      32'(busy),      32'd0);
    chk("init_req_ready", 32'(req_ready), 32'd1);

    // Store then load at 0x10.
    transact(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, rd, er, lat);
    chk("st10_lat", 32'(lat), 32'd2);
    chk("st10_err", 32'(er), 32'd0);
    chk("st10_rdata", rd, 32'd0);
    transact(1'b0, 32'h10, 32'h0, 0, 1'b0, rd, er, lat);
    chk("ld10_lat", 32'(lat), 32'd2);
    chk("ld10_rdata", rd, 32'hDEADBEEF);
    chk("ld10_err", 32'(er), 32'd0);

    // Misaligned store must not write.
    transact(1'b1, 32'h13, 32'h12345678, 0, 1'b0, rd, er, lat);
    chk("st13_err", 32'(er), 32'd1);
    chk("st13_rdata", rd, 32'd0);
    transact(1'b0, 32'h10, 32'h0, 0, 1'b0, rd, er, lat);
    chk("ld10b_rdata", rd, 32'hDEADBEEF);

    // Back-pressure with req_valid held high.
    transact(1'b0, 32'h10, 32'h0, 5, 1'b1, rd, er, lat);
    chk("stall_rdata", rd, 32'hDEADBEEF);

    // Reset during WAIT discards a pending store.
    transact(1'b1, 32'h20, 32'h11112222, 0, 1'b0, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    req_valid = 1'b0;
    chk("wait_busy", 32'(busy), 32'd1);
    clr = 1'b0;
    #1;
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    clr = 1'b1;
    repeat (3) @(negedge clk);
    transact(1'b0, 32'h20, 32'h0, 0, 1'b0, rd, er, lat);
    chk("ld20_rdata", rd, 32'h11112222);
    chk("ld20_err", 32'(er), 32'd0);

    // Range boundaries.
    transact(1'b1, 32'h0, 32'h0, 0, 1'b0, rd, er, lat);
    transact(1'b1, 32'h3FC, 32'hA5A55A5A, 0, 1'b0, rd, er, lat);
    transact(1'b0, 32'h3FC, 32'h0, 0, 1'b0, rd, er, lat);
    chk("ld3fc_err", 32'(er), 32'd0);
    chk("ld3fc_rdata", rd, 32'hA5A55A5A);
    transact(1'b0, 32'h400, 32'h0, 0, 1'b0, rd, er, lat);
    chk("ld400_err", 32'(er), 32'd1);
    chk("ld400_rdata", rd, 32'd0);
    transact(1'b1, 32'h400, 32'hFFFFFFFF, 0, 1'b0, rd, er, lat);
    chk("st400_err", 32'(er), 32'd1);
    transact(1'b0, 32'h0, 32'h0, 0, 1'b0, rd, er, lat);
    chk("ld0_rdata", rd, 32'd0);
    chk("ld0_err", 32'(er), 32'd0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
